// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters.
// Round-robin (or fixed) grant, one op in flight, result held until taken.
module alu_share_arbiter #(
    parameter int WIDTH      = 64,
    parameter int OPW        = 4,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             busy,
    output logic             grant_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   ptr;
    logic   gnt;
    logic   accept;
    logic   rsp_hs;

    always_comb begin
        gnt = req1_valid;
        if (req0_valid && req1_valid)
            gnt = FIXED_PRIO ? 1'b0 : ptr;
    end

    // Readies are forced low while reset is held, whatever the state.
    assign req0_ready = reset & (state == IDLE) & ~gnt & req0_valid;
    assign req1_ready = reset & (state == IDLE) &  gnt & req1_valid;
    assign accept     = req0_ready | req1_ready;

    assign rsp0_valid = (state == RESP) & ~grant_id;
    assign rsp1_valid = (state == RESP) &  grant_id;
    assign rsp_hs     = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr        <= 1'b0;
            grant_id   <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            if (accept) begin
                ptr      <= ~gnt;
                grant_id <= gnt;
                alu_a    <= gnt ? req1_a  : req0_a;
                alu_b    <= gnt ? req1_b  : req0_b;
                alu_op   <= gnt ? req1_op : req0_op;
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: round-robin instance plus a
// fixed-priority instance sharing the same request stimulus.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_ready, rsp1_ready;

    logic        a_rdy0, a_rdy1, a_rv0, a_rv1, a_rz, a_az, a_busy, a_gid;
    logic [63:0] a_res, a_aa, a_ab, a_ar;
    logic [3:0]  a_aop;
    logic        b_rdy0, b_rdy1, b_rv0, b_rv1, b_rz, b_az, b_busy, b_gid;
    logic [63:0] b_res, b_aa, b_ab, b_ar;
    logic [3:0]  b_aop;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Reference ALU; BLT reports its outcome on the zero flag.
    function automatic logic [64:0] alu_f(logic [63:0] a, logic [63:0] b,
                                          logic [3:0] op);
        logic [63:0] r;
        logic        z;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b1100: r = ~(a | b);
            4'b1000: r = {63'd0, $signed(a) < $signed(b)};
            default: r = '0;
        endcase
        z = (op == 4'b1000) ? r[0] : (r == '0);
        return {z, r};
    endfunction

    assign {a_az, a_ar} = alu_f(a_aa, a_ab, a_aop);
    assign {b_az, b_ar} = alu_f(b_aa, b_ab, b_aop);

    alu_share_arbiter #(.WIDTH(64), .OPW(4), .FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(a_rdy0),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(a_rdy1),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(a_rv0), .rsp0_ready(rsp0_ready),
        .rsp1_valid(a_rv1), .rsp1_ready(rsp1_ready),
        .rsp_result(a_res), .rsp_zero(a_rz),
        .alu_a(a_aa), .alu_b(a_ab), .alu_op(a_aop),
        .alu_result(a_ar), .alu_zero(a_az),
        .busy(a_busy), .grant_id(a_gid)
    );

    alu_share_arbiter #(.WIDTH(64), .OPW(4), .FIXED_PRIO(1'b1)) dut_fx (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(b_rdy0),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(b_rdy1),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(b_rv0), .rsp0_ready(rsp0_ready),
        .rsp1_valid(b_rv1), .rsp1_ready(rsp1_ready),
        .rsp_result(b_res), .rsp_zero(b_rz),
        .alu_a(b_aa), .alu_b(b_ab), .alu_op(b_aop),
        .alu_result(b_ar), .alu_zero(b_az),
        .busy(b_busy), .grant_id(b_gid)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Held in reset with both requests pending
        repeat (2) cyc();
        chk("rst_rdy0", a_rdy0, 0);
        chk("rst_rdy1", a_rdy1, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_rv0", a_rv0, 0);
        chk("rst_rv1", a_rv1, 0);
        chk("rst_gid", a_gid, 0);
        chk("rst_alu_a", a_aa, 0);
        chk("rst_alu_b", a_ab, 0);
        chk("rst_alu_op", a_aop, 0);
        chk("rst_res", a_res, 0);
        chk("rst_zero", a_rz, 0);
        chk("rst_fx_rdy0", b_rdy0, 0);
        chk("rst_fx_busy", b_busy, 0);

        // Single ADD from req0
        reset = 1'b1; req1_valid = 1'b0;
        req0_a = 64'd5; req0_b = 64'd7; req0_op = 4'b0010;
        #1;
        chk("add_rdy0", a_rdy0, 1);
        chk("add_rdy1", a_rdy1, 0);
        cyc();
        chk("add_rdy0_exec", a_rdy0, 0);
        chk("add_busy", a_busy, 1);
        chk("add_alu_a", a_aa, 5);
        chk("add_alu_b", a_ab, 7);
        chk("add_alu_op", a_aop, 4'b0010);
        chk("add_gid", a_gid, 0);
        chk("add_rv0_exec", a_rv0, 0);
        req0_valid = 1'b0;
        cyc();
        chk("add_rv0", a_rv0, 1);
        chk("add_rv1", a_rv1, 0);
        chk("add_res", a_res, 12);
        chk("add_zero", a_rz, 0);
        rsp0_ready = 1'b1;
        cyc();
        chk("add_idle_busy", a_busy, 0);
        chk("add_idle_rv0", a_rv0, 0);

        // AND from req1, then held in RESP by backpressure
        req1_valid = 1'b1; req1_a = 64'hF0; req1_b = 64'h3C; req1_op = 4'b0000;
        #1;
        chk("bp_rdy1", a_rdy1, 1);
        chk("bp_rdy0", a_rdy0, 0);
        cyc();
        chk("bp_gid", a_gid, 1);
        chk("bp_alu_a", a_aa, 64'hF0);
        req1_a = 64'd3; req1_b = 64'd4; req1_op = 4'b1000;
        req0_valid = 1'b1; req0_a = 64'd9; req0_b = 64'd9; req0_op = 4'b0110;
        cyc();
        for (int i = 0; i < 10; i++) begin
            chk("bp_rv1", a_rv1, 1);
            chk("bp_rv0", a_rv0, 0);
            chk("bp_res", a_res, 64'h30);
            chk("bp_zero", a_rz, 0);
            chk("bp_busy", a_busy, 1);
            chk("bp_gid_hold", a_gid, 1);
            chk("bp_no_rdy0", a_rdy0, 0);
            chk("bp_no_rdy1", a_rdy1, 0);
            cyc();
        end
        rsp1_ready = 1'b1;
        #1;
        chk("bp_hs_rv1", a_rv1, 1);
        chk("bp_hs_no_rdy0", a_rdy0, 0);
        cyc();

        // Contention: SUB 9-9 on req0, BLT 3<4 on req1, alternating
        for (int i = 0; i < 4; i++) begin
            logic g;
            g = i[0];
            chk("ct_idle_busy", a_busy, 0);
            chk("ct_rdy0", a_rdy0, !g);
            chk("ct_rdy1", a_rdy1, g);
            cyc();
            chk("ct_gid", a_gid, g);
            chk("ct_alu_op", a_aop, g ? 4'b1000 : 4'b0110);
            chk("ct_busy", a_busy, 1);
            cyc();
            chk("ct_rv0", a_rv0, !g);
            chk("ct_rv1", a_rv1, g);
            chk("ct_res", a_res, g ? 64'd1 : 64'd0);
            chk("ct_zero", a_rz, 1);
            cyc();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Reset during EXEC drops the transaction and clears ptr
        req0_valid = 1'b1; req0_a = 64'd1; req0_b = 64'd2; req0_op = 4'b0001;
        #1;
        chk("mr_rdy0", a_rdy0, 1);
        cyc();
        chk("mr_exec_busy", a_busy, 1);
        reset = 1'b0; req0_valid = 1'b0;
        cyc();
        chk("mr_busy", a_busy, 0);
        chk("mr_rv0", a_rv0, 0);
        chk("mr_alu_a", a_aa, 0);
        chk("mr_alu_op", a_aop, 0);
        chk("mr_res", a_res, 0);
        chk("mr_gid", a_gid, 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("mr_no_rv0", a_rv0, 0);
            chk("mr_idle", a_busy, 0);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("mr_ptr_rdy0", a_rdy0, 1);
        chk("mr_ptr_rdy1", a_rdy1, 0);

        // Fixed priority: req0 always wins while it stays valid
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fx_rdy0", b_rdy0, 1);
            chk("fx_rdy1", b_rdy1, 0);
            cyc();
            chk("fx_gid", b_gid, 0);
            chk("fx_rdy1_exec", b_rdy1, 0);
            cyc();
            chk("fx_rv0", b_rv0, 1);
            chk("fx_rv1", b_rv1, 0);
            chk("fx_res", b_res, 64'd3);
            cyc();
        end
        req0_valid = 1'b0;
        #1;
        chk("fx_rdy1_after", b_rdy1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
